// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//
// Main control unit for a multicycle RV32 subset datapath (lw, sw, R-type,
// beq). A Moore state machine steers the shared memory, ALU and register
// file through fetch / decode / execute / writeback. Unsupported opcodes
// park the machine in TRAP until reset. A retired-instruction counter
// increments on each return to FETCH that completes an instruction.
//
// Ports
//   clk            in   single clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   opcode[6:0]    in   instruction opcode (sampled in DECODE and MEMADR)
//   zero           in   ALU zero flag, used in BEQ
//   mem_ready      in   memory access completes this cycle
//   pc_write       out  PC enable
//   adr_src        out  memory address select (0 PC, 1 ALUOut)
//   mem_write      out  memory write strobe
//   ir_write       out  instruction register enable
//   result_src     out  result mux (00 ALUOut, 01 mem data, 10 ALU result)
//   alu_src_a      out  ALU A mux (00 PC, 01 OldPC, 10 reg A)
//   alu_src_b      out  ALU B mux (00 reg B, 01 ImmExt, 10 const 4)
//   alu_op         out  ALU control (00 add, 01 sub, 10 funct decode)
//   reg_write      out  register file write enable
//   illegal_instr  out  high while parked in TRAP
//   instr_retired  out  completed-instruction count, wraps
//   state_o        out  current state encoding
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instr_retired,
    output logic [3:0]       state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_BEQ      = 4'd8,
        S_TRAP     = 4'd9
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Ungated enables; the async reset masks them below.
    logic pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw;
    logic retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write_raw  = 1'b0;
        adr_src       = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_write_raw = 1'b0;
        retire        = 1'b0;

        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write_raw = 1'b1;
                    pc_write_raw = 1'b1;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively form the branch target in ALUOut.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYP:      state_d = S_EXECR;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src    = 2'b01;
                reg_write_raw = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a    = 2'b10;
                alu_op       = 2'b01;
                pc_write_raw = zero;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            // Encodings 10-15 are unreachable; recover quietly to FETCH.
            default: begin
                state_d = S_FETCH;
            end
        endcase

        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Reset forces FETCH asynchronously, and FETCH would otherwise raise
    // ir_write/pc_write combinationally from mem_ready; mask every enable.
    assign pc_write      = pc_write_raw  & rst_n;
    assign mem_write     = mem_write_raw & rst_n;
    assign ir_write      = ir_write_raw  & rst_n;
    assign reg_write     = reg_write_raw & rst_n;
    assign illegal_instr = (state_q == S_TRAP);
    assign instr_retired = cnt_q;
    assign state_o       = state_q;

endmodule
